// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin fetch/data arbiter and sequencer for a single Avalon-style bus
module mem_bus_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_address,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      r_state;
  logic        r_last_d;
  logic        r_gnt_d;
  logic [31:0] r_cnt;
  logic        w_gnt_d;
  logic        w_st;
  logic        w_to;
  logic [31:0] w_rdata;
  // last_grant resets to data so fetch wins the first contention
  assign w_gnt_d = d_req && (!f_req || !r_last_d);
  assign w_st    = w_gnt_d && d_write;
  assign w_to    = (TIMEOUT != 0) && waitrequest && (r_cnt == 32'(TIMEOUT - 1));
  assign w_rdata = (write || waitrequest) ? 32'h0 : readdata;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_gnt_d    <= 1'b0;
      r_cnt      <= '0;
      f_ack      <= 1'b0;
      f_rdata    <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (f_req || d_req) begin
          r_state    <= ACCESS;
          r_gnt_d    <= w_gnt_d;
          r_cnt      <= '0;
          busy       <= 1'b1;
          read       <= !w_st;
          write      <= w_st;
          address    <= w_gnt_d ? d_address : f_address;
          writedata  <= w_gnt_d ? d_writedata : 32'h0;
          byteenable <= w_gnt_d ? d_byteenable : 4'hf;
        end
        ACCESS: if (!waitrequest || w_to) begin
          r_state    <= RESP;
          r_last_d   <= r_gnt_d;
          read       <= 1'b0;
          write      <= 1'b0;
          address    <= '0;
          writedata  <= '0;
          byteenable <= '0;
          f_ack      <= !r_gnt_d;
          d_ack      <= r_gnt_d;
          f_rdata    <= r_gnt_d ? 32'h0 : w_rdata;
          d_rdata    <= r_gnt_d ? w_rdata : 32'h0;
          timeout    <= timeout || waitrequest;
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
        RESP: begin
          r_state <= IDLE;
          f_ack   <= 1'b0;
          d_ack   <= 1'b0;
          f_rdata <= '0;
          d_rdata <= '0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors with hand-computed expectations, TIMEOUT=8
module tb_mem_bus_arbiter;
  logic        clk, reset;
  logic        f_req, f_ack, d_req, d_write, d_ack;
  logic [31:0] f_address, f_rdata, d_address, d_writedata, d_rdata;
  logic [3:0]  d_byteenable, byteenable;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest, busy, timeout;
  int          n_vec, n_err;

  mem_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_address(f_address), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_zero(input logic [31:0] a, input logic [31:0] d, input logic to_exp);
    f_req = 1'b1; f_address = a; readdata = d; waitrequest = 1'b0;
    tick;
    chk("fz_read", read, 1);
    chk("fz_write", write, 0);
    chk("fz_addr", address, a);
    chk("fz_be", byteenable, 4'hf);
    chk("fz_wd", writedata, 0);
    chk("fz_busy", busy, 1);
    tick;
    chk("fz_read_off", read, 0);
    chk("fz_fack", f_ack, 1);
    chk("fz_frdata", f_rdata, d);
    chk("fz_dack", d_ack, 0);
    chk("fz_timeout", timeout, to_exp);
    f_req = 1'b0;
    tick;
    chk("fz_fack_off", f_ack, 0);
    chk("fz_idle", busy, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0; f_req = 0; d_req = 0; d_write = 0;
    f_address = 0; d_address = 0; d_writedata = 0; d_byteenable = 0;
    readdata = 0; waitrequest = 0;
    tick; tick;
    chk("rst_read", read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b1;
    tick;

    // reset mid-transfer, checked between clock edges
    f_req = 1; f_address = 32'h0000_0040; waitrequest = 1;
    tick;
    chk("mid_read", read, 1);
    tick;
    chk("mid_read2", read, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_read_async", read, 0);
    chk("mid_busy_async", busy, 0);
    chk("mid_fack_async", f_ack, 0);
    chk("mid_addr_async", address, 0);
    f_req = 0;
    tick;
    reset = 1'b1;
    tick;
    chk("mid_no_ack", f_ack, 0);

    fetch_zero(32'hBFC0_0000, 32'h8C02_0004, 1'b0);

    // store with three wait cycles and address churn during ACCESS
    d_req = 1; d_write = 1; d_address = 32'h1000; d_writedata = 32'hDEAD_BEEF;
    d_byteenable = 4'h3; readdata = 32'h1234_5678; waitrequest = 1;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("st_write", write, 1);
      chk("st_read", read, 0);
      chk("st_addr", address, 32'h1000);
      chk("st_wd", writedata, 32'hDEAD_BEEF);
      chk("st_be", byteenable, 4'h3);
      chk("st_dack_early", d_ack, 0);
      if (i == 1) begin d_address = 32'hFFFF_0000; d_writedata = 0; d_byteenable = 4'hc; end
      if (i == 3) waitrequest = 0;
      tick;
    end
    chk("st_write_off", write, 0);
    chk("st_dack", d_ack, 1);
    chk("st_drdata", d_rdata, 0);
    chk("st_fack", f_ack, 0);
    d_req = 0; d_write = 0;
    tick;
    chk("st_dack_off", d_ack, 0);

    // contention from reset: fetch, data, fetch
    reset = 1'b0;
    f_req = 1; f_address = 32'h0000_0100; d_req = 1; d_address = 32'h0000_2000;
    d_byteenable = 4'hf; readdata = 32'hCAFE_0001; waitrequest = 0;
    tick;
    reset = 1'b1;
    tick;
    chk("ct1_addr", address, 32'h0000_0100);
    chk("ct1_read", read, 1);
    tick;
    chk("ct1_fack", f_ack, 1);
    chk("ct1_dack", d_ack, 0);
    chk("ct1_drdata", d_rdata, 0);
    tick;
    chk("ct1_idle", busy, 0);
    tick;
    chk("ct2_addr", address, 32'h0000_2000);
    chk("ct2_read", read, 1);
    tick;
    chk("ct2_dack", d_ack, 1);
    chk("ct2_drdata", d_rdata, 32'hCAFE_0001);
    chk("ct2_fack", f_ack, 0);
    tick;
    tick;
    chk("ct3_addr", address, 32'h0000_0100);
    f_req = 0; d_req = 0;
    tick;
    chk("ct3_fack", f_ack, 1);
    tick;

    // watchdog on a load: read high exactly 8 cycles
    d_req = 1; d_write = 0; d_address = 32'h3000; readdata = 32'hAAAA_5555; waitrequest = 1;
    tick;
    for (int i = 0; i < 8; i++) begin
      chk("to_read", read, 1);
      chk("to_flag_early", timeout, 0);
      tick;
    end
    chk("to_read_off", read, 0);
    chk("to_flag", timeout, 1);
    chk("to_dack", d_ack, 1);
    chk("to_drdata", d_rdata, 0);
    d_req = 0;
    tick;
    chk("to_dack_off", d_ack, 0);
    fetch_zero(32'h0000_0200, 32'h0BAD_F00D, 1'b1);
    chk("to_sticky", timeout, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter and sequencer for the CPU's single Avalon-style memory bus, sitting between the multicycle control path and the `address/read/write/waitrequest/readdata` pins of `mips_cpu_bus`. It accepts instruction-fetch and data-access requests over req/ack handshakes, grants one at a time round-robin, and holds bus signals stable across `waitrequest`. It returns read data and aborts stalled transfers with a watchdog.

## Interface
- `TIMEOUT`, default 256: max consecutive cycles `waitrequest` may stay high in one transfer; 0 disables the watchdog.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request; held high until `f_ack`.
- `f_address`  in  32  fetch byte address.
- `f_ack`  out  1  one-cycle fetch completion pulse.
- `f_rdata`  out  32  fetched word; valid while `f_ack`=1.
- `d_req`  in  1  data request; held high until `d_ack`.
- `d_write`  in  1  1 = store, 0 = load.
- `d_address`  in  32  data byte address.
- `d_writedata`  in  32  store data.
- `d_byteenable`  in  4  store/load lane enables.
- `d_ack`  out  1  one-cycle data completion pulse.
- `d_rdata`  out  32  load word; valid while `d_ack`=1.
- `address`  out  32  bus address.
- `read`  out  1  bus read strobe.
- `write`  out  1  bus write strobe.
- `writedata`  out  32  bus write data.
- `byteenable`  out  4  bus lane enables.
- `waitrequest`  in  1  slave stall.
- `readdata`  in  32  bus read data.
- `busy`  out  1  high in ACCESS or RESP.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if neither req high, stay. If one high, grant it. If both high, grant the requester not granted last (`last_grant` register; reset value = data, so fetch wins first contention). On grant latch address, write, writedata, byteenable into a transfer register; go ACCESS.
- Fetch grant: write=0, byteenable=4'b1111, writedata=0.
- ACCESS: drive `read`=~wr or `write`=wr, plus latched address/writedata/byteenable, all constant for whole state. Watchdog counter cleared on entry and incremented each cycle `waitrequest`=1.
- Completion: rising edge with `waitrequest`=0 in ACCESS. Capture `readdata` (loads/fetches; stores capture 0) into response register; update `last_grant`; go RESP.
- Watchdog: if `TIMEOUT`≠0 and counter reaches `TIMEOUT` while `waitrequest`=1, drop strobes, set `timeout`=1, response data = 32'h0, go RESP.
- RESP: assert ack of granted requester for exactly one cycle, drive its rdata from response register; go IDLE. Strobes low.
- Requests sampled only in IDLE; a req still high in the cycle after ack is treated as a new request (requesters must drop req after ack).
- Ungranted requester's ack stays 0; its rdata is 0.
- `timeout` clears only on reset.

## Timing
- Reset asserted (any state, including mid-transfer): immediately and asynchronously all outputs 0, state IDLE, counter 0, `last_grant`=data, `timeout`=0. No ack is produced for the aborted transfer.
- Zero-wait transfer: req sampled high at edge N (IDLE) → strobe high in cycle N+1 → ack high in cycle N+2 → IDLE in N+3. A new request is re-granted no earlier than edge N+3.
- Each `waitrequest` cycle adds exactly one cycle to ACCESS.
- Timeout path: strobe high for exactly `TIMEOUT` cycles, then ack one cycle later.
- `read` and `write` are never high together; strobes never high outside ACCESS.
- Requester input changes during ACCESS/RESP have no effect on bus outputs.

## Test plan
- Reset mid-transfer: assert `reset`=0 while `read`=1, `waitrequest`=1 → `read`, `f_ack`, `busy` go 0 without a clock edge; after release, first request is serviced normally.
- Single fetch, zero wait: `f_req`=1, `f_address`=0xBFC00000, `readdata`=0x8C020004 → `read`=1, `byteenable`=0xF one cycle, then `f_ack`=1 with `f_rdata`=0x8C020004.
- Store with 3 wait cycles: `d_write`=1, `d_address`=0x1000, `d_writedata`=0xDEADBEEF, `d_byteenable`=0x3 → `write` high 4 cycles with stable outputs, then `d_ack`=1.
- Contention: `f_req` and `d_req` both high from reset → fetch served first, then data, then fetch again if both remain high.
- Timeout: `TIMEOUT`=8, `waitrequest` held 1 on a load → `read` high 8 cycles, `timeout`=1, `d_ack`=1, `d_rdata`=0; `timeout` stays 1 across later transfers.
- Input churn: change `d_address` during ACCESS → `address` holds the latched value.
